core_ctrl_fsm: RTL and testbench
================================

// Module: core_ctrl_fsm
// PURPOSE
//  Multi-cycle sequencer for the unprivileged RV32 core. Issues instruction fetch, loads the
//  instruction register feeding the combinational decoder, then steps the datapath through
//  execute / memory / writeback using the decoder flags. Drives PC update and register-file
//  write enable, and traps on illegal instructions. Sits between imem/dmem ports and datapath.
// PARAMETERS
//  TIMEOUT_CYCLES  255  ready-wait limit in FETCH/MEM before trap (used only with MEM_TIMEOUT_EN)
//  TO_W            8    width of timeout counter; must hold TIMEOUT_CYCLES
// PORTS
//  clk           in   1  core clock, all state on rising edge
//  rst           in   1  asynchronous, active-high reset
//  run           in   1  level: 1 = keep issuing instructions
//  imem_ready    in   1  instruction memory data valid this cycle
//  imem_req      out  1  instruction fetch request
//  ir_we         out  1  load instruction register
//  dec_illegal   in   1  decoder: unknown opcode
//  dec_is_branch in   1  decoder: B-type
//  dec_jal       in   1  decoder: JAL
//  dec_jalr      in   1  decoder: JALR
//  dec_is_load   in   1  decoder: load
//  dec_is_store  in   1  decoder: store
//  dec_reg_write in   1  decoder: instruction writes rd
//  br_taken      in   1  ALU branch compare result (valid in EXEC..WB)
//  dmem_ready    in   1  data memory access complete
//  dmem_req      out  1  data memory request
//  dmem_we       out  1  data memory write (store)
//  rf_we         out  1  register-file write enable
//  wb_sel        out  2  00 ALU result, 01 load data, 10 PC+4
//  pc_we         out  1  PC register write enable
//  pc_sel        out  2  00 PC+4, 01 PC+imm, 10 (rs1+imm)&~1
//  retire        out  1  one-cycle pulse per completed instruction
//  trap          out  1  sticky trap indicator
//  trap_cause    out  2  00 none, 01 illegal, 10 memory timeout
//  state         out  3  current state encoding (debug)
// BEHAVIOUR
//  States: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 TRAP=6; 7 unused -> IDLE.
//  Reset (async, any time): state=IDLE; all outputs 0 immediately; in-flight req dropped.
//  IDLE: outputs 0; run=1 -> FETCH next cycle.
//  FETCH: imem_req=1 held until imem_ready; ir_we=imem_ready (Mealy, same cycle); -> DECODE.
//  DECODE: 1 cycle; dec_illegal -> TRAP (trap_cause=01), else -> EXEC.
//  EXEC: 1 cycle; dec_is_load|dec_is_store -> MEM, else -> WB.
//  MEM: dmem_req=1, dmem_we=dec_is_store, both held until dmem_ready; then -> WB.
//  WB: pc_we=1, retire=1; rf_we=dec_reg_write & ~dec_is_store & ~dec_is_branch;
//   wb_sel=10 if jal|jalr, 01 if load, else 00;
//   pc_sel=10 if jalr, 01 if jal or (branch & br_taken), else 00; jalr has priority.
//   -> FETCH if run=1, else IDLE.
//  TRAP: trap=1, all other outputs 0; exits only via rst.
//  run=0 mid-instruction: instruction completes through WB, then IDLE.
//  Latency (zero-wait memory): ALU/branch/jump 4 cycles FETCH..WB; load/store 5.
//  Outputs except ir_we are Moore (decoded from state and decoder flags).
// CONFIGURATION
//  MEM_TIMEOUT_EN defined: counter clears on entering FETCH/MEM, increments each non-ready cycle;
//   when it reaches TIMEOUT_CYCLES with ready still 0 -> TRAP, trap_cause=10; ready in that same
//   cycle wins (normal transition). Counter also clears on rst.
//  Not defined: no counter; FETCH/MEM wait indefinitely; trap_cause never 10.
// TESTING
//  rst mid-MEM with dmem_req=1 -> dmem_req=0 and state=0 in same cycle, before next clk edge.
//  run=1, ready tied 1, ADD (reg_write=1) -> states 1,2,3,5; rf_we=1, wb_sel=00, pc_sel=00, retire=1.
//  Load, dmem_ready after 3 waits -> MEM held 4 cycles with dmem_req=1, dmem_we=0; WB wb_sel=01.
//  Branch br_taken=1 -> WB pc_sel=01, rf_we=0; br_taken=0 -> pc_sel=00; JALR -> pc_sel=10, wb_sel=10.
//  dec_illegal=1 in DECODE -> TRAP, trap=1, trap_cause=01, no pc_we/retire; holds until rst.
//  MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, imem_ready=0 -> TRAP after 4 FETCH cycles, trap_cause=10.

Source files
------------

// File: rtl/core_ctrl_fsm.sv
// core_ctrl_fsm: multi-cycle RV32 sequencer.
// Optional ready-wait timeout via MEM_TIMEOUT_EN.
module core_ctrl_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       imem_ready,
  output logic       imem_req,
  output logic       ir_we,
  input  logic       dec_illegal,
  input  logic       dec_is_branch,
  input  logic       dec_jal,
  input  logic       dec_jalr,
  input  logic       dec_is_load,
  input  logic       dec_is_store,
  input  logic       dec_reg_write,
  input  logic       br_taken,
  input  logic       dmem_ready,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       retire,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [1:0] C_NONE = 2'b00;
  localparam logic [1:0] C_ILL  = 2'b01;
  localparam logic [1:0] C_TO   = 2'b10;

  state_t     state_q;
  state_t     state_d;
  logic [1:0] cause_q;
  logic [1:0] cause_d;
  logic       to_hit;

`ifdef MEM_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic            waiting;

  assign waiting =
    ((state_q == S_FETCH) && !imem_ready) ||
    ((state_q == S_MEM) && !dmem_ready);

  assign to_hit = waiting &&
    (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (waiting) begin
      to_cnt <= to_cnt + 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cause_q <= C_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready) begin
          state_d = S_DECODE;
        end else if (to_hit) begin
          state_d = S_TRAP;
          cause_d = C_TO;
        end
      end
      S_DECODE: begin
        if (dec_illegal) begin
          state_d = S_TRAP;
          cause_d = C_ILL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (dec_is_load || dec_is_store)
          state_d = S_MEM;
        else
          state_d = S_WB;
      end
      S_MEM: begin
        if (dmem_ready) begin
          state_d = S_WB;
        end else if (to_hit) begin
          state_d = S_TRAP;
          cause_d = C_TO;
        end
      end
      S_WB: begin
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 2'b00;
    pc_we    = 1'b0;
    pc_sel   = 2'b00;
    retire   = 1'b0;
    trap     = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_is_store;
      end
      S_WB: begin
        pc_we  = 1'b1;
        retire = 1'b1;
        rf_we  = dec_reg_write &
                 ~dec_is_store &
                 ~dec_is_branch;
        if (dec_jal || dec_jalr)
          wb_sel = 2'b10;
        else if (dec_is_load)
          wb_sel = 2'b01;
        if (dec_jalr)
          pc_sel = 2'b10;
        else if (dec_jal ||
                 (dec_is_branch && br_taken))
          pc_sel = 2'b01;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign trap_cause = cause_q;
  assign state      = state_q;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// tb_core_ctrl_fsm: scoreboard bench for core_ctrl_fsm.
// Expected vectors queued by driver, checked at negedge.
module tb_core_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       imem_ready = 1'b0;
  logic       dec_illegal = 1'b0;
  logic       dec_is_branch = 1'b0;
  logic       dec_jal = 1'b0;
  logic       dec_jalr = 1'b0;
  logic       dec_is_load = 1'b0;
  logic       dec_is_store = 1'b0;
  logic       dec_reg_write = 1'b0;
  logic       br_taken = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       imem_req;
  logic       ir_we;
  logic       dmem_req;
  logic       dmem_we;
  logic       rf_we;
  logic [1:0] wb_sel;
  logic       pc_we;
  logic [1:0] pc_sel;
  logic       retire;
  logic       trap;
  logic [1:0] trap_cause;
  logic [2:0] state;

  core_ctrl_fsm #(
    .TIMEOUT_CYCLES(4),
    .TO_W(8)
  ) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_ready(imem_ready),
    .imem_req(imem_req), .ir_we(ir_we),
    .dec_illegal(dec_illegal),
    .dec_is_branch(dec_is_branch),
    .dec_jal(dec_jal), .dec_jalr(dec_jalr),
    .dec_is_load(dec_is_load),
    .dec_is_store(dec_is_store),
    .dec_reg_write(dec_reg_write),
    .br_taken(br_taken),
    .dmem_ready(dmem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .rf_we(rf_we), .wb_sel(wb_sel),
    .pc_we(pc_we), .pc_sel(pc_sel),
    .retire(retire), .trap(trap),
    .trap_cause(trap_cause),
    .state(state)
  );

  always #5 clk = ~clk;

  wire [16:0] obs = {state, imem_req, ir_we,
                     dmem_req, dmem_we, rf_we,
                     wb_sel, pc_we, pc_sel,
                     retire, trap, trap_cause};

  typedef struct packed {
    logic ill, br, jal, jalr, ld, st, rw;
  } flags_t;

  localparam flags_t F_ADD  = 7'b0000001;
  localparam flags_t F_LD   = 7'b0000101;
  localparam flags_t F_ST   = 7'b0000011;
  localparam flags_t F_BR   = 7'b0100000;
  localparam flags_t F_JAL  = 7'b0010001;
  localparam flags_t F_JALR = 7'b0001001;
  localparam flags_t F_ILL  = 7'b1000000;

  typedef struct {
    string       tag;
    logic [16:0] v;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag,
                     input logic [16:0] got,
                     input logic [16:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk(e.tag, obs, e.v);
    end
  end

  function automatic logic [16:0] v_st(
    input logic [2:0] s);
    return {s, 14'b0};
  endfunction

  function automatic logic [16:0] v_fetch(
    input logic rdy);
    return {3'd1, 1'b1, rdy, 12'b0};
  endfunction

  function automatic logic [16:0] v_mem(
    input logic we);
    return {3'd4, 2'b00, 1'b1, we, 10'b0};
  endfunction

  function automatic logic [16:0] v_wb(
    input logic       rfwe,
    input logic [1:0] wbs,
    input logic [1:0] pcs);
    return {3'd5, 4'b0, rfwe, wbs, 1'b1,
            pcs, 1'b1, 3'b0};
  endfunction

  function automatic logic [16:0] v_trap(
    input logic [1:0] c);
    return {3'd6, 11'b0, 1'b1, c};
  endfunction

  task automatic step(input string tag,
                      input logic [16:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input flags_t f);
    {dec_illegal, dec_is_branch, dec_jal,
     dec_jalr, dec_is_load, dec_is_store,
     dec_reg_write} = f;
  endtask

  task automatic instr(input string nm,
                       input flags_t f,
                       input int iw,
                       input int dw,
                       input logic tk,
                       input logic run_after);
    logic       rfwe;
    logic [1:0] wbs;
    logic [1:0] pcs;
    set_flags(f);
    br_taken = tk;
    for (int i = 0; i < iw; i++) begin
      imem_ready = 1'b0;
      step({nm, ".fwait"}, v_fetch(1'b0));
    end
    imem_ready = 1'b1;
    step({nm, ".fetch"}, v_fetch(1'b1));
    imem_ready = 1'b0;
    run = run_after;
    step({nm, ".dec"}, v_st(3'd2));
    if (f.ill) begin
      for (int i = 0; i < 3; i++)
        step({nm, ".trap"}, v_trap(2'b01));
      return;
    end
    step({nm, ".exec"}, v_st(3'd3));
    if (f.ld || f.st) begin
      for (int i = 0; i < dw; i++) begin
        dmem_ready = 1'b0;
        step({nm, ".mwait"}, v_mem(f.st));
      end
      dmem_ready = 1'b1;
      step({nm, ".mem"}, v_mem(f.st));
      dmem_ready = 1'b0;
    end
    rfwe = f.rw & ~f.st & ~f.br;
    wbs  = (f.jal || f.jalr) ? 2'b10 :
           (f.ld ? 2'b01 : 2'b00);
    pcs  = f.jalr ? 2'b10 :
           ((f.jal || (f.br && tk)) ?
            2'b01 : 2'b00);
    step({nm, ".wb"}, v_wb(rfwe, wbs, pcs));
    if (!run_after)
      step({nm, ".idle"}, v_st(3'd0));
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk("reset", obs, 17'd0);
    rst = 1'b0;
    step("idle0", v_st(3'd0));
    step("idle1", v_st(3'd0));
    run = 1'b1;
    step("idle_go", v_st(3'd0));

    instr("add",  F_ADD,  0, 0, 1'b0, 1'b1);
    instr("ld",   F_LD,   1, 3, 1'b0, 1'b1);
    instr("st",   F_ST,   0, 2, 1'b0, 1'b1);
    instr("br_t", F_BR,   0, 0, 1'b1, 1'b1);
    instr("br_n", F_BR,   0, 0, 1'b0, 1'b1);
    instr("jal",  F_JAL,  0, 0, 1'b0, 1'b1);
    instr("jalr", F_JALR, 0, 0, 1'b1, 1'b1);
`ifndef MEM_TIMEOUT_EN
    instr("slowf", F_ADD, 6, 0, 1'b0, 1'b1);
`endif
    instr("stop", F_ADD,  0, 0, 1'b0, 1'b0);
    step("idle_hold", v_st(3'd0));

    run = 1'b1;
    step("r.idle", v_st(3'd0));
    set_flags(F_LD);
    imem_ready = 1'b1;
    step("r.fetch", v_fetch(1'b1));
    imem_ready = 1'b0;
    step("r.dec", v_st(3'd2));
    step("r.exec", v_st(3'd3));
    dmem_ready = 1'b0;
    step("r.mwait0", v_mem(1'b0));
    step("r.mwait1", v_mem(1'b0));
    #2;
    chk("r.pre_req", {16'b0, dmem_req}, 17'd1);
    rst = 1'b1;
    #1;
    chk("r.async", obs, 17'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("r.idle2", v_st(3'd0));

    instr("ill", F_ILL, 0, 0, 1'b0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("trap.rst", obs, 17'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

`ifdef MEM_TIMEOUT_EN
    set_flags(F_ADD);
    step("to.idle", v_st(3'd0));
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      step("to.fwait", v_fetch(1'b0));
    step("to.trap0", v_trap(2'b10));
    step("to.trap1", v_trap(2'b10));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
`endif

    run = 1'b0;
    step("end.idle", v_st(3'd0));
    @(negedge clk);
    #1;
    chk("q.empty", 17'(q.size()), 17'd0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
